// File: rtl/bcd_count_sequencer_if.sv
// Control/status bundle for the two-digit BCD count sequencer.
// master drives the controls; slave is the sequencer itself.
interface bcd_count_sequencer_if;
  logic       en;
  logic       sel;
  logic       wrap_en;
  logic       load;
  logic [7:0] preset;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       tc;
  logic       wrapped;
  logic       load_err;
  logic [1:0] state;

  modport master (
    output en, sel, wrap_en, load, preset,
    input  tens, ones, tc, wrapped, load_err, state
  );

  modport slave (
    input  en, sel, wrap_en, load, preset,
    output tens, ones, tc, wrapped, load_err, state
  );
endinterface

// File: rtl/bcd_count_sequencer.sv
// Two-digit BCD up/down counter with run/pause, preset load, programmable top,
// wrap or stop-at-limit, and one-cycle tc / wrapped / load_err pulses.
module bcd_count_sequencer #(
  parameter int TOP = 99
) (
  input  logic                   div_clk,
  input  logic                   rst,
  bcd_count_sequencer_if.slave   bus
);

  localparam logic [3:0] TOP_T = 4'(TOP / 10);
  localparam logic [3:0] TOP_O = 4'(TOP % 10);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_e;

  state_e     state_q;
  logic [3:0] tens_q, ones_q;
  logic [3:0] tens_d, ones_d;
  logic       tc_q, wrapped_q, load_err_q;

  logic at_top, at_zero, at_limit, lands_limit, preset_ok, leave_done;

  assign at_top  = (tens_q == TOP_T) && (ones_q == TOP_O);
  assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

  // Digit-wise step in the direction of sel; only consumed when not at a limit,
  // so tens never over/underflows here.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (bus.sel) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else begin
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  assign at_limit    = bus.sel ? at_top : at_zero;
  assign lands_limit = bus.sel ? ((tens_d == TOP_T) && (ones_d == TOP_O))
                               : ((tens_d == 4'd0) && (ones_d == 4'd0));

  assign preset_ok = (bus.preset[7:4] <= 4'd9) && (bus.preset[3:0] <= 4'd9) &&
                     ((bus.preset[7:4] < TOP_T) ||
                      ((bus.preset[7:4] == TOP_T) && (bus.preset[3:0] <= TOP_O)));

  // DONE is left only by requesting a step away from the limit we stopped at.
  assign leave_done = bus.en && ((at_top && !bus.sel) || (at_zero && bus.sel));

  always_ff @(posedge div_clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      tc_q       <= 1'b0;
      wrapped_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      tc_q       <= 1'b0;
      wrapped_q  <= 1'b0;
      load_err_q <= 1'b0;
      if (bus.load) begin
        if (preset_ok) begin
          tens_q  <= bus.preset[7:4];
          ones_q  <= bus.preset[3:0];
          state_q <= IDLE;
        end else begin
          load_err_q <= 1'b1;
        end
      end else begin
        case (state_q)
          IDLE, PAUSE: if (bus.en) state_q <= COUNT;
          COUNT: begin
            if (!bus.en) begin
              state_q <= PAUSE;
            end else if (at_limit) begin
              if (bus.wrap_en) begin
                tens_q    <= bus.sel ? 4'd0 : TOP_T;
                ones_q    <= bus.sel ? 4'd0 : TOP_O;
                wrapped_q <= 1'b1;
              end else begin
                state_q <= DONE;
              end
            end else begin
              tens_q <= tens_d;
              ones_q <= ones_d;
              tc_q   <= lands_limit;
            end
          end
          DONE: if (leave_done) state_q <= COUNT;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.tens     = tens_q;
  assign bus.ones     = ones_q;
  assign bus.tc       = tc_q;
  assign bus.wrapped  = wrapped_q;
  assign bus.load_err = load_err_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Bench for bcd_count_sequencer: TOP=99 and TOP=45 instances share stimulus,
// directed scenarios plus random traffic against an integer reference model.
module tb_bcd_count_sequencer;

  logic       div_clk;
  logic       rst, en, sel, wrap_en, load;
  logic [7:0] preset;
  int         total = 0;
  int         bad   = 0;

  bcd_count_sequencer_if if99 ();
  bcd_count_sequencer_if if45 ();

  assign if99.en = en;  assign if99.sel = sel;  assign if99.wrap_en = wrap_en;
  assign if99.load = load;  assign if99.preset = preset;
  assign if45.en = en;  assign if45.sel = sel;  assign if45.wrap_en = wrap_en;
  assign if45.load = load;  assign if45.preset = preset;

  bcd_count_sequencer #(.TOP(99)) u99 (.div_clk(div_clk), .rst(rst), .bus(if99));
  bcd_count_sequencer #(.TOP(45)) u45 (.div_clk(div_clk), .rst(rst), .bus(if45));

  initial div_clk = 1'b0;
  always #5 div_clk = ~div_clk;

  // Reference model: count as a plain integer, mode 0=idle 1=count 2=pause 3=done.
  int m_cnt [2];
  int m_st  [2];
  bit m_tc  [2];
  bit m_wr  [2];
  bit m_le  [2];

  function automatic int top_of(int k);
    return (k == 0) ? 99 : 45;
  endfunction

  task automatic model_step();
    int top, pt, po;
    for (int k = 0; k < 2; k++) begin
      top = top_of(k);
      m_tc[k] = 0; m_wr[k] = 0; m_le[k] = 0;
      if (!rst) begin
        m_cnt[k] = 0; m_st[k] = 0;
      end else if (load) begin
        pt = int'(preset) / 16;
        po = int'(preset) % 16;
        if (pt <= 9 && po <= 9 && pt * 10 + po <= top) begin
          m_cnt[k] = pt * 10 + po; m_st[k] = 0;
        end else m_le[k] = 1;
      end else begin
        case (m_st[k])
          0, 2: if (en) m_st[k] = 1;
          1: begin
            if (!en) m_st[k] = 2;
            else if (sel) begin
              if (m_cnt[k] == top) begin
                if (wrap_en) begin m_cnt[k] = 0; m_wr[k] = 1; end else m_st[k] = 3;
              end else begin
                m_cnt[k]++; m_tc[k] = (m_cnt[k] == top);
              end
            end else begin
              if (m_cnt[k] == 0) begin
                if (wrap_en) begin m_cnt[k] = top; m_wr[k] = 1; end else m_st[k] = 3;
              end else begin
                m_cnt[k]--; m_tc[k] = (m_cnt[k] == 0);
              end
            end
          end
          default: if (en && ((m_cnt[k] == top && !sel) || (m_cnt[k] == 0 && sel))) m_st[k] = 1;
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge div_clk);
    model_step();
    #1;
  endtask

  function automatic logic [12:0] w99();
    return {if99.tens, if99.ones, if99.tc, if99.wrapped, if99.load_err, if99.state};
  endfunction
  function automatic logic [12:0] w45();
    return {if45.tens, if45.ones, if45.tc, if45.wrapped, if45.load_err, if45.state};
  endfunction
  function automatic logic [12:0] ew(int c, bit t, bit w, bit l, int s);
    return {4'(c / 10), 4'(c % 10), t, w, l, 2'(s)};
  endfunction

  task automatic test_reset();
    rst = 0; load = 1; preset = 8'h12; en = 1; sel = 1; wrap_en = 1;
    tick();
    total++; if (w99() !== ew(0,0,0,0,0)) begin bad++; $display("FAIL reset99 got=%h exp=%h", w99(), ew(0,0,0,0,0)); end
    total++; if (w45() !== ew(0,0,0,0,0)) begin bad++; $display("FAIL reset45 got=%h exp=%h", w45(), ew(0,0,0,0,0)); end
    rst = 1; load = 0; en = 0;
    tick();
  endtask

  task automatic test_first_step();
    en = 1; sel = 1;
    tick();
    total++; if (w99() !== ew(0,0,0,0,1)) begin bad++; $display("FAIL first_resume got=%h exp=%h", w99(), ew(0,0,0,0,1)); end
    tick();
    total++; if (w99() !== ew(1,0,0,0,1)) begin bad++; $display("FAIL first_step got=%h exp=%h", w99(), ew(1,0,0,0,1)); end
  endtask

  task automatic test_up_wrap();
    logic [12:0] exp [5];
    exp = '{ew(97,0,0,0,1), ew(98,0,0,0,1), ew(99,1,0,0,1), ew(0,0,1,0,1), ew(1,0,0,0,1)};
    en = 0; load = 1; preset = 8'h97;
    tick();
    total++; if (w99() !== ew(97,0,0,0,0)) begin bad++; $display("FAIL wrap_load got=%h exp=%h", w99(), ew(97,0,0,0,0)); end
    load = 0; en = 1; sel = 1; wrap_en = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (w99() !== exp[i]) begin bad++; $display("FAIL up_wrap[%0d] got=%h exp=%h", i, w99(), exp[i]); end
    end
  endtask

  task automatic test_down_stop();
    logic [12:0] exp [5];
    exp = '{ew(2,0,0,0,1), ew(1,0,0,0,1), ew(0,1,0,0,1), ew(0,0,0,0,3), ew(0,0,0,0,3)};
    en = 0; load = 1; preset = 8'h02;
    tick();
    load = 0; en = 1; sel = 0; wrap_en = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (w99() !== exp[i]) begin bad++; $display("FAIL down_stop[%0d] got=%h exp=%h", i, w99(), exp[i]); end
    end
    sel = 1;
    tick();
    total++; if (w99() !== ew(0,0,0,0,1)) begin bad++; $display("FAIL done_exit got=%h exp=%h", w99(), ew(0,0,0,0,1)); end
    tick();
    total++; if (w99() !== ew(1,0,0,0,1)) begin bad++; $display("FAIL done_step got=%h exp=%h", w99(), ew(1,0,0,0,1)); end
  endtask

  task automatic test_borrow_top45();
    en = 0; load = 1; preset = 8'h40;
    tick();
    load = 0; en = 1; sel = 0;
    tick(); tick();
    total++; if (w45() !== ew(39,0,0,0,1)) begin bad++; $display("FAIL borrow got=%h exp=%h", w45(), ew(39,0,0,0,1)); end
    load = 1; preset = 8'h44;
    tick();
    load = 0; sel = 1; wrap_en = 0;
    tick(); tick();
    total++; if (w45() !== ew(45,1,0,0,1)) begin bad++; $display("FAIL top45_tc got=%h exp=%h", w45(), ew(45,1,0,0,1)); end
    wrap_en = 1;
    tick();
    total++; if (w45() !== ew(0,0,1,0,1)) begin bad++; $display("FAIL top45_wrap_up got=%h exp=%h", w45(), ew(0,0,1,0,1)); end
    sel = 0;
    tick();
    total++; if (w45() !== ew(45,0,1,0,1)) begin bad++; $display("FAIL top45_wrap_dn got=%h exp=%h", w45(), ew(45,0,1,0,1)); end
  endtask

  task automatic test_invalid_load();
    en = 0; load = 1; preset = 8'h3A;
    tick();
    total++; if (w45() !== ew(45,0,0,1,1)) begin bad++; $display("FAIL bad_digit got=%h exp=%h", w45(), ew(45,0,0,1,1)); end
    preset = 8'h50;
    tick();
    total++; if (w45() !== ew(45,0,0,1,1)) begin bad++; $display("FAIL over_top got=%h exp=%h", w45(), ew(45,0,0,1,1)); end
    load = 0;
    tick();
    total++; if (w45() !== ew(45,0,0,0,2)) begin bad++; $display("FAIL err_pulse_end got=%h exp=%h", w45(), ew(45,0,0,0,2)); end
    load = 1; preset = 8'h12;
    tick();
    total++; if (w45() !== ew(12,0,0,0,0)) begin bad++; $display("FAIL good_load got=%h exp=%h", w45(), ew(12,0,0,0,0)); end
    load = 0;
  endtask

  task automatic test_priority_pause();
    logic [12:0] exp [6];
    exp = '{ew(20,0,0,0,1), ew(21,0,0,0,1), ew(21,0,0,0,2), ew(21,0,0,0,2), ew(21,0,0,0,1), ew(22,0,0,0,1)};
    load = 1; en = 1; preset = 8'h20;
    tick();
    total++; if (w99() !== ew(20,0,0,0,0)) begin bad++; $display("FAIL load_wins99 got=%h exp=%h", w99(), ew(20,0,0,0,0)); end
    total++; if (w45() !== ew(20,0,0,0,0)) begin bad++; $display("FAIL load_wins45 got=%h exp=%h", w45(), ew(20,0,0,0,0)); end
    load = 0; sel = 1; wrap_en = 1;
    for (int i = 0; i < 6; i++) begin
      en = (i == 2 || i == 3) ? 1'b0 : 1'b1;
      tick();
      total++; if (w99() !== exp[i]) begin bad++; $display("FAIL pause[%0d] got=%h exp=%h", i, w99(), exp[i]); end
    end
    rst = 0; load = 1; preset = 8'h33;
    tick();
    total++; if (w99() !== ew(0,0,0,0,0)) begin bad++; $display("FAIL rst_over_load got=%h exp=%h", w99(), ew(0,0,0,0,0)); end
    rst = 1; load = 0;
  endtask

  task automatic test_random();
    logic [12:0] e99, e45;
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 99) != 0);
      load    = ($urandom_range(0, 15) == 0);
      preset  = ($urandom_range(0, 3) == 0) ? 8'($urandom) :
                {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      en      = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) sel = ~sel;
      if ($urandom_range(0, 15) == 0) wrap_en = ~wrap_en;
      tick();
      e99 = ew(m_cnt[0], m_tc[0], m_wr[0], m_le[0], m_st[0]);
      e45 = ew(m_cnt[1], m_tc[1], m_wr[1], m_le[1], m_st[1]);
      total++; if (w99() !== e99) begin bad++; $display("FAIL rand99 n=%0d got=%h exp=%h", n, w99(), e99); end
      total++; if (w45() !== e45) begin bad++; $display("FAIL rand45 n=%0d got=%h exp=%h", n, w45(), e45); end
    end
  endtask

  initial begin
    rst = 0; en = 0; sel = 0; wrap_en = 0; load = 0; preset = 8'h00;
    m_cnt = '{0, 0}; m_st = '{0, 0};
    m_tc = '{0, 0}; m_wr = '{0, 0}; m_le = '{0, 0};
    test_reset();
    test_first_step();
    test_up_wrap();
    test_down_stop();
    test_borrow_top45();
    test_invalid_load();
    test_priority_pause();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
